// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for a standard-mode SRAM FIFO: pops words, buffers them in a 2-entry
// skid buffer and presents them on a valid/ready stream. Optional error flag: FIFO_RD_STREAM_ERR_EN.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 36
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef FIFO_RD_STREAM_ERR_EN
  ,
  input  logic                  fifo_rderr_i,
  output logic                  err_o
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  drop_q, drop_d;

  logic                  fire;
  logic                  capture;
  logic [2:0]            occupancy;

  // Occupancy counts words already buffered plus the one returning from the SRAM this cycle.
  always_comb begin
    fire       = valid_o & ready_i;
    capture    = inflight_q & ~drop_q;
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fire};
    fifo_pop_o = rst_ni & ~flush_i & ~fifo_empty_i & (occupancy < 3'd2);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = fifo_pop_o;
    drop_d     = 1'b0;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      drop_d   = inflight_q;
    end else begin
      if (capture) wr_ptr_d = ~wr_ptr_q;
      if (fire)    rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, capture} - {1'b0, fire};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (!flush_i && capture) begin
      mem_q[wr_ptr_q] <= fifo_data_i;
    end
  end

  always_comb begin
    valid_o = (count_q != 2'd0);
    data_o  = mem_q[rd_ptr_q];
  end

`ifdef FIFO_RD_STREAM_ERR_EN
  logic err_q, err_d;

  // Capturing into a full buffer can only happen if the pop rule is broken.
  always_comb begin
    if (flush_i) err_d = 1'b0;
    else         err_d = err_q | fifo_rderr_i | (capture & (count_q == 2'd2));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a vector table for the basic drain, then FIFO-model
// sequences for backpressure, empty/refill, flush, mid-stream reset and the optional error flag.
module tb_fifo_rd_stream;
  localparam int unsigned DW = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic          ready_i = 1'b0;
  logic [DW-1:0] tab_data = '0;
  logic [DW-1:0] model_data = '0;
  logic          use_model = 1'b0;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_pop_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
`ifdef FIFO_RD_STREAM_ERR_EN
  logic          fifo_rderr_i = 1'b0;
  logic          err_o;
`endif

  assign fifo_data_i = use_model ? model_data : tab_data;

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_pop_o   (fifo_pop_o),
    .fifo_data_i  (fifo_data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o)
`ifdef FIFO_RD_STREAM_ERR_EN
    ,
    .fifo_rderr_i (fifo_rderr_i),
    .err_o        (err_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fq[$];  // FIFO contents
  logic [DW-1:0] eq[$];  // words expected on the stream, in order

  // Standard-mode FIFO: read data appears the cycle after a pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_data <= '0;
    else if (flush_i) fq.delete();
    else if (fifo_pop_o && fq.size() != 0) model_data <= fq.pop_front();
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then score any accepted word.
  task automatic step(input logic rdy, input logic fl);
    @(negedge clk);
    ready_i = rdy;
    flush_i = fl;
    if (use_model) fifo_empty_i = (fq.size() == 0);
    #1;
    if (valid_o && rdy && !fl) begin
      if (eq.size() == 0) check("unexpected_word", data_o, '1);
      else check("stream_data", data_o, eq.pop_front());
    end
    if (fl) eq.delete();
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    eq.push_back(w);
  endtask

  // Push n words into an idle engine and drain with ready held high.
  task automatic run_stream(input int n, input logic [DW-1:0] base);
    int pops = 0;
    int first = -1;
    for (int i = 0; i < n; i++) push(base + DW'(i));
    for (int c = 0; c < 20 && eq.size() != 0; c++) begin
      step(1'b1, 1'b0);
      if (fifo_pop_o) pops++;
      if (valid_o && first < 0) first = c;
    end
    check("stream_pops", DW'(pops), DW'(n));
    check("first_valid_cycle", DW'(first), DW'(2));
    check("stream_drained", DW'(eq.size()), DW'(0));
  endtask

  typedef struct {
    logic          empty;
    logic [DW-1:0] fdata;
    logic          pop;
    logic          valid;
    logic          chk_d;
    logic [DW-1:0] dout;
  } vec_t;

  localparam logic [DW-1:0] WA = 36'hA_0000_00A1;
  localparam logic [DW-1:0] WB = 36'hB_0000_00B2;
  localparam logic [DW-1:0] WC = 36'hC_0000_00C3;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[7];
    logic [DW-1:0] z;
    logic [DW-1:0] w[8];
    z = '0;
    // A,B,C drained with ready high: pop in cycles 1..3, words out in cycles 3..5.
    tab[0] = '{1'b1, z,  1'b0, 1'b0, 1'b1, z};
    tab[1] = '{1'b0, z,  1'b1, 1'b0, 1'b1, z};
    tab[2] = '{1'b0, WA, 1'b1, 1'b0, 1'b1, z};
    tab[3] = '{1'b0, WB, 1'b1, 1'b1, 1'b1, WA};
    tab[4] = '{1'b1, WC, 1'b0, 1'b1, 1'b1, WB};
    tab[5] = '{1'b1, z,  1'b0, 1'b1, 1'b1, WC};
    tab[6] = '{1'b1, z,  1'b0, 1'b0, 1'b0, z};

    // Reset state, with the FIFO reporting data to show the pop is gated by reset.
    fifo_empty_i = 1'b0;
    ready_i = 1'b1;
    #12;
    check("reset_pop", DW'(fifo_pop_o), DW'(0));
    check("reset_valid", DW'(valid_o), DW'(0));
    check("reset_data", data_o, z);
`ifdef FIFO_RD_STREAM_ERR_EN
    check("reset_err", DW'(err_o), DW'(0));
`endif
    fifo_empty_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      fifo_empty_i = tab[i].empty;
      tab_data = tab[i].fdata;
      ready_i = 1'b1;
      #1;
      check($sformatf("tab%0d_pop", i), DW'(fifo_pop_o), DW'(tab[i].pop));
      check($sformatf("tab%0d_valid", i), DW'(valid_o), DW'(tab[i].valid));
      if (tab[i].chk_d) check($sformatf("tab%0d_data", i), data_o, tab[i].dout);
    end

    use_model = 1'b1;

    // Backpressure: 8 words, consumer stalled in cycles 3..6.
    for (int i = 0; i < 8; i++) begin
      w[i] = 36'h5_0000_0000 + DW'(i);
      push(w[i]);
    end
    for (int c = 0; c < 40 && eq.size() != 0; c++) begin
      step(!(c >= 3 && c <= 6), 1'b0);
      if (c >= 3 && c <= 6) begin
        check($sformatf("bp%0d_pop_blocked", c), DW'(fifo_pop_o), DW'(0));
        check($sformatf("bp%0d_data_held", c), data_o, w[1]);
      end
      if (c == 6) check("bp_full_valid", DW'(valid_o), DW'(1));
    end
    check("bp_all_delivered", DW'(eq.size()), DW'(0));

    // Empty after one word, refill later with X.
    run_stream(1, 36'h1_1111_1111);
    step(1'b1, 1'b0);
    check("empty_valid_drop", DW'(valid_o), DW'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("empty_idle_pop", DW'(fifo_pop_o), DW'(0));
    run_stream(1, 36'h7_7777_7777);

    // Flush with D in flight; D must never appear, E streams normally.
    step(1'b1, 1'b0);
    push(36'hD_DDDD_DDDD);
    step(1'b1, 1'b0);
    check("flush_prepop", DW'(fifo_pop_o), DW'(1));
    step(1'b1, 1'b1);
    check("flush_pop_low", DW'(fifo_pop_o), DW'(0));
    step(1'b1, 1'b0);
    check("flush_valid_low", DW'(valid_o), DW'(0));
    step(1'b1, 1'b0);
    check("flush_no_d", DW'(valid_o), DW'(0));
    run_stream(1, 36'hE_EEEE_EEEE);

    // Reset mid-stream with the buffer full.
    for (int i = 0; i < 4; i++) push(36'h9_0000_0000 + DW'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("rst_pre_valid", DW'(valid_o), DW'(1));
    check("rst_pre_pop", DW'(fifo_pop_o), DW'(0));
    @(negedge clk);
    rst_n = 1'b0;
    fq.delete();
    eq.delete();
    fifo_empty_i = 1'b0;
    #1;
    check("rst_mid_valid", DW'(valid_o), DW'(0));
    check("rst_mid_pop", DW'(fifo_pop_o), DW'(0));
    @(negedge clk);
    fifo_empty_i = 1'b1;
    rst_n = 1'b1;
    run_stream(3, 36'h3_0000_0000);

`ifdef FIFO_RD_STREAM_ERR_EN
    step(1'b1, 1'b0);
    check("err_idle", DW'(err_o), DW'(0));
    @(negedge clk);
    fifo_rderr_i = 1'b1;
    @(negedge clk);
    fifo_rderr_i = 1'b0;
    #1;
    check("err_set", DW'(err_o), DW'(1));
    step(1'b1, 1'b0);
    check("err_held", DW'(err_o), DW'(1));
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("err_flushed", DW'(err_o), DW'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
